// File: rtl/fifo_mem_pkg.sv
// Shared types and constants for the FIFO memory write-side blocks.
//   arb_state_e : write-port arbiter state (idle / burst owner active)
//   FIFO_DATA_W : default FIFO data width, shared with the FIFO interface
package fifo_mem_pkg;

  localparam int FIFO_DATA_W = 16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_mem_rr_pick.sv
// Combinational round-robin priority picker.
// Scans req_i ascending from start_i, wrapping modulo N; the first set bit wins.
// When excl_en_i is set, excl_idx_i is skipped, but only if some other
// requester is also asking (a lone requester is never starved by the mask).
// Ports:
//   req_i      : request vector
//   start_i    : index that gets highest priority
//   excl_idx_i : index to de-prioritise
//   excl_en_i  : enable for the exclusion
//   found_o    : at least one candidate exists
//   win_o      : winning index (0 when found_o=0)
module fifo_mem_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  input  logic [IW-1:0] excl_idx_i,
  input  logic          excl_en_i,
  output logic          found_o,
  output logic [IW-1:0] win_o
);

  logic [N-1:0] masked;
  logic [N-1:0] cand;
  logic         done;

  always_comb begin
    masked = req_i;
    cand   = req_i;
    if (excl_en_i) begin
      masked[excl_idx_i] = 1'b0;
      if (|masked) cand = masked;
    end
    found_o = |cand;
    win_o   = '0;
    done    = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(start_i) + k;
      if (idx >= N) idx = idx - N;
      if (!done && cand[idx]) begin
        win_o = IW'(idx);
        done  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_mem_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A winner owns the port for up to BURST_LEN accepted beats (one beat while
// the FIFO is at/above threshold). Writes are only issued while the FIFO is
// not full; a full stall keeps the grant and the beat count.
// Ports:
//   clk, areset_b           : clock, async active-low reset
//   req_valid/req_data      : producer requests, data flattened per requester
//   req_ready               : per-producer accept (one-hot or zero)
//   full_ind/threshold_ind  : FIFO status, current cycle
//   overflow_ind            : FIFO overflow pulse
//   trans_write/data_in     : FIFO write strobe and data
//   grant_valid/grant_idx   : current port owner
//   err_overflow/err_clr    : sticky overflow flag and its synchronous clear
module fifo_mem_wr_arbiter
  import fifo_mem_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = FIFO_DATA_W,
  parameter int BURST_LEN  = 4,
  localparam int IDX_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          areset_b,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full_ind,
  input  logic                          threshold_ind,
  input  logic                          overflow_ind,
  output logic                          trans_write,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          err_overflow,
  input  logic                          err_clr
);

  arb_state_e       state_q;
  logic [IDX_W-1:0] gidx_q;
  logic [IDX_W-1:0] rr_q;
  logic [CNT_W-1:0] beat_q;
  logic             err_q;

  logic             in_burst, own_vld, accept;
  logic [CNT_W:0]   beat_inc, eff_len;
  logic             rel_len, rel_idle, rel_any;
  logic             found;
  logic [IDX_W-1:0] win, win_nxt;

  assign in_burst = (state_q == ARB_BURST);
  assign own_vld  = req_valid[gidx_q];
  assign accept   = in_burst && own_vld && !full_ind;

  // Compare one bit wider so beat_q+1 cannot wrap at BURST_LEN.
  assign beat_inc = {1'b0, beat_q} + (CNT_W+1)'(1);
  assign eff_len  = threshold_ind ? (CNT_W+1)'(1) : (CNT_W+1)'(BURST_LEN);

  assign rel_len  = accept && (beat_inc >= eff_len);
  assign rel_idle = in_burst && !own_vld;
  assign rel_any  = rel_len || rel_idle;

  // Only a completed burst pushes the owner to the back; an idle owner
  // is not requesting anyway, so no mask is needed.
  fifo_mem_rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
    .req_i      (req_valid),
    .start_i    (rr_q),
    .excl_idx_i (gidx_q),
    .excl_en_i  (rel_len),
    .found_o    (found),
    .win_o      (win)
  );

  assign win_nxt = (win == IDX_W'(NUM_REQ-1)) ? '0 : win + IDX_W'(1);

  always_ff @(posedge clk or negedge areset_b) begin
    if (!areset_b) begin
      state_q <= ARB_IDLE;
      gidx_q  <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // Set wins over clear.
      err_q <= overflow_ind | (err_q & ~err_clr);
      case (state_q)
        ARB_IDLE: begin
          if (found) begin
            state_q <= ARB_BURST;
            gidx_q  <= win;
            beat_q  <= '0;
            rr_q    <= win_nxt;
          end
        end
        ARB_BURST: begin
          if (rel_any) begin
            beat_q <= '0;
            if (found) begin
              gidx_q <= win;
              rr_q   <= win_nxt;
            end else begin
              state_q <= ARB_IDLE;
            end
          end else if (accept && (beat_q != CNT_W'(BURST_LEN))) begin
            beat_q <= beat_q + CNT_W'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Ready follows full_ind combinationally so a full FIFO blocks the
  // handshake in the same cycle.
  always_comb begin
    req_ready = '0;
    if (in_burst && !full_ind) req_ready[gidx_q] = 1'b1;
  end

  assign trans_write  = accept;
  assign data_in      = accept ? req_data[gidx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign grant_valid  = in_burst;
  assign grant_idx    = gidx_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_fifo_mem_wr_arbiter.sv
module tb_fifo_mem_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int BL = 4;

  logic             clk = 1'b0;
  logic             areset_b;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             full_ind, threshold_ind, overflow_ind, err_clr;
  logic             trans_write;
  logic [DW-1:0]    data_in;
  logic             grant_valid;
  logic [1:0]       grant_idx;
  logic             err_overflow;

  fifo_mem_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk           (clk),
    .areset_b      (areset_b),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .full_ind      (full_ind),
    .threshold_ind (threshold_ind),
    .overflow_ind  (overflow_ind),
    .trans_write   (trans_write),
    .data_in       (data_in),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .err_overflow  (err_overflow),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Producer models: requester i sends {i[3:0], seq[11:0]} while enabled with beats left.
  logic [NR-1:0] en;
  int            rem [NR];
  int            seq [NR];

  // Scoreboard of expected writes: {owner index, data}.
  logic [19:0]   sb [$];

  task automatic push(input int idx, input int s);
    sb.push_back({4'(idx), 16'((idx << 12) | s)});
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = en[i] && (rem[i] > 0);
      req_data[i*DW +: DW] = 16'((i << 12) | seq[i]);
    end
  endtask

  // One clock: sample/score at negedge, advance producers just after posedge.
  task automatic tick();
    logic [19:0]   exp;
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    if (trans_write) begin
      checks++;
      if (!areset_b) begin
        failures++; $display("FAIL write_in_reset trans_write=1 required 0");
      end else if (full_ind) begin
        failures++; $display("FAIL write_while_full trans_write=1 required 0");
      end else if (sb.size() == 0) begin
        failures++; $display("FAIL unexpected_write idx=%0d data=%h", grant_idx, data_in);
      end else begin
        exp = sb.pop_front();
        if ({4'(grant_idx), data_in} !== exp)
          begin failures++; $display("FAIL write_order got=%h required=%h", {4'(grant_idx), data_in}, exp); end
      end
    end
    checks++;
    if ((req_ready & (req_ready - 4'd1)) !== 4'd0)
      begin failures++; $display("FAIL ready_onehot got=%b", req_ready); end
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) if (acc[i]) begin seq[i]++; rem[i]--; end
    drive();
  endtask

  task automatic do_reset();
    areset_b = 1'b0;
    full_ind = 1'b0; threshold_ind = 1'b0; overflow_ind = 1'b0; err_clr = 1'b0;
    en = '0;
    for (int i = 0; i < NR; i++) begin rem[i] = 0; seq[i] = 1; end
    drive();
    tick(); tick();
    areset_b = 1'b1;
  endtask

  task automatic sb_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL %s_drain pending=%0d required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    areset_b = 1'b0; en = '0; full_ind = 1'b0; threshold_ind = 1'b0;
    overflow_ind = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < NR; i++) begin rem[i] = 0; seq[i] = 1; end
    drive();
    #2;
    checks++;
    if ({grant_valid, grant_idx, req_ready, trans_write, data_in, err_overflow} !== '0)
      begin failures++; $display("FAIL reset_outputs gv=%b gi=%0d rdy=%b tw=%b d=%h err=%b required 0",
        grant_valid, grant_idx, req_ready, trans_write, data_in, err_overflow); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    en = 4'b0001; rem[0] = 6;
    for (int s = 1; s <= 6; s++) push(0, s);
    drive(); #1;
    checks++;
    if (grant_valid !== 1'b0 || trans_write !== 1'b0)
      begin failures++; $display("FAIL single_latency gv=%b tw=%b required 0 0", grant_valid, trans_write); end
    tick();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 2'd0)
        begin failures++; $display("FAIL single_grant gv=%b idx=%0d required 1 0", grant_valid, grant_idx); end
      tick();
    end
    sb_drained("single");
    tick(); tick();
    checks++;
    if (grant_valid !== 1'b0)
      begin failures++; $display("FAIL single_release gv=%b required 0", grant_valid); end
  endtask

  task automatic test_contention();
    do_reset();
    en = 4'b0101; rem[0] = 8; rem[2] = 4;
    for (int s = 1; s <= 4; s++) push(0, s);
    for (int s = 1; s <= 4; s++) push(2, s);
    for (int s = 5; s <= 8; s++) push(0, s);
    drive();
    tick();
    checks++;
    if (grant_idx !== 2'd0)
      begin failures++; $display("FAIL contention_first idx=%0d required 0", grant_idx); end
    for (int c = 0; c < 12; c++) tick();
    sb_drained("contention");
  endtask

  task automatic test_full_stall();
    do_reset();
    en = 4'b0011; rem[0] = 8; rem[1] = 4;
    for (int s = 1; s <= 4; s++) push(0, s);
    for (int s = 1; s <= 4; s++) push(1, s);
    for (int s = 5; s <= 8; s++) push(0, s);
    drive();
    tick(); tick(); tick();
    full_ind = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (trans_write !== 1'b0 || req_ready !== 4'b0000 || grant_valid !== 1'b1 || grant_idx !== 2'd0)
        begin failures++; $display("FAIL stall_hold tw=%b rdy=%b gv=%b idx=%0d required 0 0000 1 0",
          trans_write, req_ready, grant_valid, grant_idx); end
      tick();
    end
    full_ind = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    sb_drained("full_stall");
  endtask

  task automatic test_valid_drop();
    do_reset();
    en = 4'b0011; rem[0] = 2; rem[1] = 4;
    push(0, 1); push(0, 2);
    for (int s = 1; s <= 4; s++) push(1, s);
    drive();
    tick(); tick(); tick();
    checks++;
    if (grant_idx !== 2'd0 || req_valid[0] !== 1'b0)
      begin failures++; $display("FAIL drop_before idx=%0d v0=%b required 0 0", grant_idx, req_valid[0]); end
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd1)
      begin failures++; $display("FAIL drop_regrant gv=%b idx=%0d required 1 1", grant_valid, grant_idx); end
    for (int c = 0; c < 4; c++) tick();
    sb_drained("valid_drop");
  endtask

  task automatic test_threshold();
    do_reset();
    threshold_ind = 1'b1;
    en = 4'b1111;
    for (int i = 0; i < NR; i++) rem[i] = 2;
    for (int r = 1; r <= 2; r++)
      for (int i = 0; i < NR; i++) push(i, r);
    drive();
    tick();
    for (int c = 0; c < 8; c++) tick();
    sb_drained("threshold");
    threshold_ind = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    overflow_ind = 1'b1; #1;
    checks++;
    if (err_overflow !== 1'b0)
      begin failures++; $display("FAIL ovf_before got=%b required 0", err_overflow); end
    tick(); overflow_ind = 1'b0; #1;
    checks++;
    if (err_overflow !== 1'b1)
      begin failures++; $display("FAIL ovf_set got=%b required 1", err_overflow); end
    tick(); tick(); #1;
    checks++;
    if (err_overflow !== 1'b1)
      begin failures++; $display("FAIL ovf_sticky got=%b required 1", err_overflow); end
    err_clr = 1'b1; overflow_ind = 1'b1;
    tick(); err_clr = 1'b0; overflow_ind = 1'b0; #1;
    checks++;
    if (err_overflow !== 1'b1)
      begin failures++; $display("FAIL ovf_set_wins got=%b required 1", err_overflow); end
    err_clr = 1'b1;
    tick(); err_clr = 1'b0; #1;
    checks++;
    if (err_overflow !== 1'b0)
      begin failures++; $display("FAIL ovf_clear got=%b required 0", err_overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 4'b0100; rem[2] = 4;
    push(2, 1);
    drive();
    tick(); tick();
    areset_b = 1'b0;
    en = '0; rem[2] = 0;
    drive(); #1;
    checks++;
    if ({grant_valid, req_ready, trans_write, data_in} !== '0)
      begin failures++; $display("FAIL reset_mid gv=%b rdy=%b tw=%b d=%h required 0",
        grant_valid, req_ready, trans_write, data_in); end
    tick(); tick();
    areset_b = 1'b1;
    en = 4'b1001; rem[0] = 1; rem[3] = 1; seq[0] = 1; seq[3] = 1;
    push(0, 1); push(3, 1);
    drive();
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd0)
      begin failures++; $display("FAIL reset_restart gv=%b idx=%0d required 1 0", grant_valid, grant_idx); end
    tick(); tick(); tick();
    sb_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full_stall();
    test_valid_drop();
    test_threshold();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_mem_wr_arbiter.md
Name: fifo_mem_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one FIFO memory write port among NUM_REQ producers. Each producer has a valid/ready handshake. The arbiter holds a grant for bursts of up to BURST_LEN beats and drives trans_write/data_in only while the FIFO is not full. It shortens bursts to one beat when the FIFO crosses its threshold, and latches a sticky error if the FIFO reports overflow. It sits between producer blocks and the FIFO memory, on the FIFO write-side signals.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 16, FIFO data width
BURST_LEN, 4, max beats per grant (>=1)
IDX_W (localparam), $clog2(NUM_REQ), grant index width
CNT_W (localparam), $clog2(BURST_LEN+1), beat counter width

Ports:
clk  in  1  clock, rising edge
areset_b  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester write request
req_data  in  NUM_REQ*DATA_WIDTH  flattened; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
full_ind  in  1  FIFO full, current cycle
threshold_ind  in  1  FIFO at/above threshold
overflow_ind  in  1  FIFO overflow pulse
trans_write  out  1  FIFO write strobe
data_in  out  DATA_WIDTH  FIFO write data
grant_valid  out  1  a requester currently owns the port
grant_idx  out  IDX_W  current owner index
err_overflow  out  1  sticky overflow flag
err_clr  in  1  synchronous clear of err_overflow

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-low on areset_b.
- Reset values:
  - state=IDLE, grant_valid=0, grant_idx=0, rr_ptr=0, beat_cnt=0, err_overflow=0.
  - Consequently req_ready=0, trans_write=0, data_in=0.
- States:
  - IDLE: no owner.
  - BURST: owner = grant_idx.
- Arbitration:
  - Search req_valid starting at rr_ptr, ascending, wrapping modulo NUM_REQ; the first set bit wins.
  - rr_ptr <= winner+1 (wrapped) whenever a new grant is issued.
- IDLE: if any req_valid, register the winner in grant_idx, set grant_valid=1, beat_cnt=0, go to BURST. The first beat is accepted no earlier than the cycle after req_valid is seen (1-cycle grant latency).
- Accept: accept = (state==BURST) && req_valid[grant_idx] && !full_ind.
  - req_ready[grant_idx] = (state==BURST) && !full_ind; combinational path from full_ind.
  - trans_write = accept.
  - data_in = req_data slice of grant_idx while accept, else 0.
- Effective burst limit: eff_len = threshold_ind ? 1 : BURST_LEN, sampled each cycle.
- Release from BURST (evaluated each cycle):
  - (a) accept && beat_cnt+1 >= eff_len.
  - (b) owner's req_valid=0 (idle beat).
  - On release, re-arbitrate in the same cycle over req_valid, excluding the current owner under (a) only when another requester is valid. If there is a winner, stay in BURST with the new grant_idx and beat_cnt=0; otherwise go to IDLE with grant_valid=0.
  - A sole requester is re-granted immediately after its burst ends.
- full_ind=1 in BURST: no accept, beat_cnt holds, grant retained. A stall never releases the grant, and no write is issued while full.
- beat_cnt increments only on accept and saturates at BURST_LEN.
- Overflow: overflow_ind=1 sets err_overflow next cycle. err_clr=1 clears it; a simultaneous set wins over clear.
- Reset mid-burst: all state returns to reset values immediately (async). The partially transferred burst is dropped and no trans_write is issued while areset_b=0.
- Requesters must hold req_data stable while req_valid=1 && !req_ready.

Decomposition:
- Package fifo_mem_pkg: typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e; the default DATA_WIDTH constant, shared with the FIFO interface.
- One sub-module, fifo_mem_rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, start pointer, exclude index/enable.
  - Outputs: found flag, winner index.

Test Plan:
- Single requester: req_valid=4'b0001, data 0x0001..0x0006, BURST_LEN=4 -> grant one cycle after valid; 6 consecutive trans_write with data in order; grant_idx stays 0 across the burst boundary.
- Contention: req_valid=4'b0101, both continuously valid -> writes alternate 4 beats from req0, then 4 from req2, then req0; no gaps beyond the burst boundary.
- Full stall: mid-burst, hold full_ind=1 for 5 cycles -> trans_write=0 and req_ready=0 throughout; grant_idx unchanged; burst resumes at the same beat_cnt once full_ind=0; no data lost or duplicated.
- Valid drop: owner deasserts after 2 of 4 beats while req1 valid -> grant moves to req1 the next cycle; rr_ptr advances.
- Threshold: threshold_ind=1 with req_valid=4'b1111 -> one beat per grant in order 0,1,2,3,0.
- Overflow/reset: pulse overflow_ind -> err_overflow=1 until err_clr; err_clr and overflow_ind in the same cycle -> stays 1. Assert areset_b=0 mid-burst -> outputs zero immediately; after release, arbitration restarts from requester 0.
